// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, single-outstanding memory requester, and a
// 2-entry {pc, instr} buffer feeding decode; redirects flush and restart fetch.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   fifo_pc    [DEPTH];
  logic [XLEN-1:0]   fifo_instr [DEPTH];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic can_req;
  logic accept;
  logic push;
  logic pop;

  // Reset gates the request so nothing is issued while rst_n is held low.
  assign can_req = rst_n && (count_q < CNT_W'(DEPTH)) && !redirect_valid;
  assign accept  = imem_req && imem_ready;
  assign push    = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
  assign pop     = (count_q != '0) && out_ready && !redirect_valid;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = fifo_instr[rd_ptr_q];
  assign out_pc    = fifo_pc[rd_ptr_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request generation
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req = can_req;
        if (can_req && imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // Only the stale response can arrive here; it is discarded.
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // PC and fetch address tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC & ADDR_MASK;
      fetch_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ADDR_MASK;
    end else if (accept) begin
      fetch_pc_q <= pc_q;
      pc_q       <= pc_q + XLEN'(4);
    end
  end

  // Two-entry circular buffer; redirect flushes and overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr_q]    <= fetch_pc_q;
        fifo_instr[wr_ptr_q] <= imem_rdata;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a memory responder plus a queue-based
// reference model of the fetch stream, checked every cycle.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: delivered stream, PC, and the one possible in-flight fetch.
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  bit          outst;
  bit          dropping;

  // Memory responder
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_data;

  // Stimulus knobs
  int unsigned ready_pct;
  int unsigned oready_pct;
  int unsigned redir_pct;
  int unsigned lat_max;
  bit          fixed_data;
  bit          force_redir;
  logic [31:0] force_target;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] low;
    low = $urandom & 32'd3;
    case ($urandom_range(3, 0))
      0:       return 32'h0000_0100 | low;
      1:       return 32'hFFFF_FFFC | low;
      2:       return 32'hFFFF_FFF8;
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge: drive, check, advance model, move to next falling edge.
  task automatic run_cycle();
    logic        rv;
    logic        redir;
    logic        exp_req;
    logic        acc;
    logic [31:0] rpc;
    logic [31:0] rdata;
    rv    = mem_busy && (mem_wait == 0);
    rdata = rv ? mem_data : $urandom;
    redir = force_redir || ($urandom_range(99, 0) < redir_pct);
    rpc   = force_redir ? (force_target | ($urandom & 32'd3)) : pick_target();
    force_redir = 1'b0;
    if (dropping && rv) redir = 1'b0;

    imem_rvalid    = rv;
    imem_rdata     = rdata;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_ready     = ($urandom_range(99, 0) < ready_pct);
    out_ready      = ($urandom_range(99, 0) < oready_pct);
    #1;

    exp_req = !outst && (q.size() < 2) && !redir;
    check32("imem_req", 32'(imem_req), 32'(exp_req));
    check32("imem_addr", imem_addr, m_pc);
    check32("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check32("out_pc", out_pc, q[0].pc);
      check32("out_instr", out_instr, q[0].instr);
    end
    acc = exp_req && imem_ready;

    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (acc) begin
      mem_busy = 1'b1;
      mem_wait = int'($urandom_range(lat_max - 1, 0));
      mem_data = fixed_data ? 32'h0050_0093 : $urandom;
    end

    if (redir) begin
      q.delete();
      m_pc = rpc & ~32'd3;
      if (outst) begin
        if (rv) outst = 1'b0;
        else    dropping = 1'b1;
      end
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (outst && rv) begin
        if (!dropping) q.push_back('{pc: m_fetch, instr: rdata});
        outst    = 1'b0;
        dropping = 1'b0;
      end
      if (acc) begin
        outst    = 1'b1;
        dropping = 1'b0;
        m_fetch  = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; leaves rst_n released at a falling edge.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    out_ready      = 1'b0;
    #1;
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_valid", 32'(out_valid), 32'd0);
    check32("rst_instr", out_instr, 32'd0);
    check32("rst_pc", out_pc, 32'd0);
    check32("rst_addr", imem_addr, 32'h0000_0000);
    q.delete();
    m_pc     = 32'h0000_0000;
    m_fetch  = '0;
    outst    = 1'b0;
    dropping = 1'b0;
    mem_busy = 1'b0;
    mem_wait = 0;
    repeat (2) @(negedge clk);
    check32("rst_hold_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic set_knobs(input int unsigned rdy, input int unsigned ordy,
                           input int unsigned rdr, input int unsigned lat, input bit fix);
    ready_pct  = rdy;
    oready_pct = ordy;
    redir_pct  = rdr;
    lat_max    = lat;
    fixed_data = fix;
  endtask

  // Run until the model is waiting on a response (bounded).
  task automatic run_until_outst(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (outst && !dropping && mem_wait > 0) found = 1'b1;
      else run_cycle();
    end
    check32(tag, 32'(found), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    force_redir = 1'b0; force_target = '0;
    set_knobs(100, 100, 0, 1, 1'b1);
    @(negedge clk);

    // Back-to-back fetch of a fixed word: addresses 0,4,8, first delivery at T+2.
    do_reset();
    run_cycle();
    run_cycle();
    check32("first_out_valid", 32'(out_valid), 32'd1);
    check32("first_out_pc", out_pc, 32'd0);
    check32("first_out_instr", out_instr, 32'h0050_0093);
    repeat (10) run_cycle();

    // Decode stalled: buffer fills with pc 0 and 4, requests stop, then drains in order.
    do_reset();
    set_knobs(100, 0, 0, 1, 1'b0);
    repeat (10) run_cycle();
    check32("stall_valid", 32'(out_valid), 32'd1);
    check32("stall_head_pc", out_pc, 32'd0);
    check32("stall_depth", 32'(q.size()), 32'd2);
    set_knobs(100, 100, 0, 1, 1'b0);
    repeat (10) run_cycle();

    // Redirect to 0x100 while waiting on a slow response.
    set_knobs(100, 100, 0, 4, 1'b0);
    run_until_outst("setup_wait_redirect");
    force_redir = 1'b1; force_target = 32'h0000_0100;
    repeat (12) run_cycle();

    // Redirect to the top of the address space; next PC wraps to 0.
    force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
    repeat (12) run_cycle();

    // Redirect landing on the response cycle with one entry buffered.
    set_knobs(100, 0, 0, 1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (outst && mem_wait == 0 && q.size() == 1) force_redir = 1'b1;
      force_target = 32'h0000_0200;
      run_cycle();
      if (i == 20) oready_pct = 100;
    end

    // Long random mix of stalls, latencies and redirects.
    set_knobs(70, 60, 8, 4, 1'b0);
    repeat (3000) run_cycle();

    // Reset pulsed while a request is outstanding.
    set_knobs(100, 50, 0, 4, 1'b0);
    run_until_outst("setup_wait_reset");
    do_reset();
    repeat (200) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL mark a valid fetch request.
REQ-005 imem_addr  output  32  SHALL carry the fetch byte address, with bits [1:0] always 0.
REQ-006 imem_ready  input  1  memory accepts a request when imem_req && imem_ready.
REQ-007 imem_rvalid  input  1  SHALL be a one-cycle pulse returning the oldest outstanding request, at least 1 cycle after acceptance.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 redirect_valid  input  1  flush and restart fetch (branch/jump taken).
REQ-010 redirect_pc  input  32  restart address; bits [1:0] SHALL be ignored and treated as 0.
REQ-011 out_valid  output  1  instruction available to decode/immediate generation.
REQ-012 out_instr  output  32  instruction word for decode (feeds immediate generator idata).
REQ-013 out_pc  output  32  fetch address of out_instr.
REQ-014 out_ready  input  1  decode consumes the head entry when out_valid && out_ready.

Function
REQ-015 Block SHALL contain a PC register, a 2-entry FIFO of {pc, instr}, and an FSM with states REQ, WAIT, DROP.
REQ-016 At most one memory request SHALL be outstanding.
REQ-017 imem_addr SHALL equal the PC register in every cycle.
REQ-018 imem_req SHALL be (state==REQ) && (fifo_count<2) && !redirect_valid.
REQ-019 REQ: on acceptance, SHALL latch PC into fetch_pc, set PC<=PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to WAIT.
REQ-020 WAIT: on imem_rvalid without redirect, SHALL push {fetch_pc, imem_rdata} into the FIFO and go to REQ.
REQ-021 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-022 out_valid SHALL equal (fifo_count!=0); out_instr/out_pc SHALL show the head entry.
REQ-023 Redirect in any state SHALL empty the FIFO and set PC<=redirect_pc; a same-cycle pop or push SHALL be ignored.
REQ-024 Redirect in REQ SHALL stay in REQ, with no request issued that cycle.
REQ-025 Redirect in WAIT without imem_rvalid SHALL go to DROP; with imem_rvalid the response SHALL be discarded and the FSM SHALL go to REQ.
REQ-026 DROP: imem_req SHALL be 0; on imem_rvalid the response SHALL be discarded and the FSM SHALL go to REQ.
REQ-027 Redirect in DROP SHALL update PC and remain in DROP.
REQ-028 Minimum latency SHALL be: request accepted in cycle T, rvalid in T+1, out_valid in T+2; next request in T+2.
REQ-029 The FIFO SHALL never overflow; with fifo_count==2 and out_ready low, imem_req SHALL stay 0.
REQ-030 out_instr/out_pc SHALL hold stable while out_valid && !out_ready.

Reset
REQ-031 While rst_n is low, the block SHALL hold state=REQ, PC=RESET_PC, fifo_count=0, fetch_pc=0, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request.
REQ-033 The first request SHALL issue in the first cycle after rst_n rises, at RESET_PC.

Verification
REQ-034 Reset release, imem_ready=1, rvalid after 1 cycle returning 32'h00500093, out_ready=1 -> imem_addr sequence 0,4,8; out_pc=0 with out_instr=32'h00500093 two cycles after the first request.
REQ-035 out_ready=0 for 10 cycles -> exactly 2 entries buffered (pc 0 and 4), imem_req=0, head stable; release -> pc 0, 4, 8 in order, none lost or duplicated.
REQ-036 Redirect to 32'h0000_0100 while in WAIT, rvalid 3 cycles later -> that response is not delivered, out_valid=0, next imem_addr=32'h100, next out_pc=32'h100.
REQ-037 Redirect in the same cycle as rvalid with fifo_count=1 -> FIFO empty next cycle, the response is dropped, next request at redirect_pc.
REQ-038 Redirect to 32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC then 0000_0000.
REQ-039 rst_n pulsed low while in WAIT -> outputs reach reset values immediately, and the first request after release is at RESET_PC.
